// File: rtl/mmi_timer_pkg.sv
// Shared constants for the MMIO tick timer: register indices, bus encodings
// and control/status bit positions.
package mmi_timer_pkg;

    localparam int MMIO_ADDR_W = 4;
    localparam int MMIO_DATA_W = 32;

    // Request encodings; 2'b11 is reserved and behaves like idle.
    localparam logic [1:0] OPM_IDLE  = 2'b00;
    localparam logic [1:0] OPM_READ  = 2'b01;
    localparam logic [1:0] OPM_WRITE = 2'b10;

    localparam logic [1:0] OK_IDLE = 2'b00;
    localparam logic [1:0] OK_DONE = 2'b01;

    localparam logic [MMIO_ADDR_W-1:0] REG_CNT_LO      = 4'd0;
    localparam logic [MMIO_ADDR_W-1:0] REG_CNT_HI      = 4'd1;
    localparam logic [MMIO_ADDR_W-1:0] REG_CMP_LO      = 4'd2;
    localparam logic [MMIO_ADDR_W-1:0] REG_CMP_HI      = 4'd3;
    localparam logic [MMIO_ADDR_W-1:0] REG_CTRL        = 4'd4;
    localparam logic [MMIO_ADDR_W-1:0] REG_STATUS      = 4'd5;
    localparam logic [MMIO_ADDR_W-1:0] REG_WDOG_RELOAD = 4'd6;
    localparam logic [MMIO_ADDR_W-1:0] REG_WDOG_CUR    = 4'd7;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQEN_BIT  = 1;
    localparam int STATUS_PEND_BIT = 0;

    typedef enum logic {
        ST_IDLE,
        ST_DONE
    } mmioState_t;

    function automatic logic opmIsAccess(input logic [1:0] opm);
        return (opm == OPM_READ) || (opm == OPM_WRITE);
    endfunction

endpackage

// File: rtl/mmi_mod_tick_timer_if.sv
// MMIO request/response bundle between a bus master and the tick timer.
interface mmi_mod_tick_timer_if;
    import mmi_timer_pkg::*;

    logic [MMIO_ADDR_W-1:0] mmioAddr;
    logic [1:0]             mmioOpm;
    logic [MMIO_DATA_W-1:0] mmioInData;
    logic [MMIO_DATA_W-1:0] mmioOutData;
    logic [1:0]             mmioOK;

    modport master (
        output mmioAddr,
        output mmioOpm,
        output mmioInData,
        input  mmioOutData,
        input  mmioOK
    );

    modport slave (
        input  mmioAddr,
        input  mmioOpm,
        input  mmioInData,
        output mmioOutData,
        output mmioOK
    );

endinterface

// File: rtl/mmi_tick_wdog.sv
// Millisecond watchdog: counts a loaded value down to zero and pulses expire
// once on the final step.
module mmi_tick_wdog
    import mmi_timer_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MMIO_DATA_W-1:0] reloadValue,
    input  logic                   load,
    input  logic                   tick,
    output logic [MMIO_DATA_W-1:0] curValue,
    output logic                   expire
);

    // A load in the same cycle as a tick takes priority and suppresses the pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            curValue <= '0;
            expire   <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (load) begin
                curValue <= reloadValue;
            end else if (tick && (curValue != '0)) begin
                curValue <= curValue - 32'd1;
                expire   <= (curValue == 32'd1);
            end
        end
    end

endmodule

// File: rtl/mmi_mod_tick_timer.sv
// 64-bit microsecond timer with compare interrupt and millisecond watchdog,
// accessed through a one-request-at-a-time MMIO handshake.
module mmi_mod_tick_timer
    import mmi_timer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                timer1MHz,
    input  logic                timer1kHz,
    mmi_mod_tick_timer_if.slave mmio,
    output logic                timerIrq,
    output logic                wdogExpire
);

    mmioState_t state;
    mmioState_t nextState;

    logic [63:0]            cnt;
    logic [63:0]            cntNext;
    logic [63:0]            cmp;
    logic [MMIO_DATA_W-1:0] snapHi;
    logic [MMIO_DATA_W-1:0] wdogReload;
    logic [MMIO_DATA_W-1:0] wdogCur;
    logic [MMIO_DATA_W-1:0] heldData;
    logic [MMIO_DATA_W-1:0] readData;
    logic                   ctrlEn;
    logic                   ctrlIrqEn;
    logic                   pend;

    logic accessFire;
    logic isRead;
    logic isWrite;
    logic wrCntLo;
    logic wrCntHi;
    logic wrCmpLo;
    logic wrCmpHi;
    logic wrCtrl;
    logic wrStatus;
    logic wrReload;
    logic rdCntLo;
    logic cntTick;
    logic cmpHit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The access fires only on the IDLE->DONE step, so a held request
    // never repeats its side effects.
    always_comb begin
        nextState        = state;
        accessFire       = 1'b0;
        isRead           = 1'b0;
        isWrite          = 1'b0;
        mmio.mmioOK      = OK_IDLE;
        mmio.mmioOutData = '0;
        case (state)
            ST_IDLE: begin
                if (opmIsAccess(mmio.mmioOpm)) begin
                    accessFire = 1'b1;
                    isRead     = (mmio.mmioOpm == OPM_READ);
                    isWrite    = (mmio.mmioOpm == OPM_WRITE);
                    nextState  = ST_DONE;
                end
            end
            ST_DONE: begin
                mmio.mmioOK      = OK_DONE;
                mmio.mmioOutData = heldData;
                if (!opmIsAccess(mmio.mmioOpm)) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        readData = '0;
        case (mmio.mmioAddr)
            REG_CNT_LO:      readData = cnt[31:0];
            REG_CNT_HI:      readData = snapHi;
            REG_CMP_LO:      readData = cmp[31:0];
            REG_CMP_HI:      readData = cmp[63:32];
            REG_CTRL: begin
                readData[CTRL_EN_BIT]    = ctrlEn;
                readData[CTRL_IRQEN_BIT] = ctrlIrqEn;
            end
            REG_STATUS:      readData[STATUS_PEND_BIT] = pend;
            REG_WDOG_RELOAD: readData = wdogReload;
            REG_WDOG_CUR:    readData = wdogCur;
            default:         readData = '0;
        endcase
    end

    always_comb begin
        wrCntLo  = isWrite && (mmio.mmioAddr == REG_CNT_LO);
        wrCntHi  = isWrite && (mmio.mmioAddr == REG_CNT_HI);
        wrCmpLo  = isWrite && (mmio.mmioAddr == REG_CMP_LO);
        wrCmpHi  = isWrite && (mmio.mmioAddr == REG_CMP_HI);
        wrCtrl   = isWrite && (mmio.mmioAddr == REG_CTRL);
        wrStatus = isWrite && (mmio.mmioAddr == REG_STATUS);
        wrReload = isWrite && (mmio.mmioAddr == REG_WDOG_RELOAD);
        rdCntLo  = isRead  && (mmio.mmioAddr == REG_CNT_LO);
        cntNext  = cnt + 64'd1;
        cntTick  = timer1MHz && ctrlEn && !(wrCntLo || wrCntHi);
        cmpHit   = cntTick && (cntNext == cmp);
    end

    // A CNT write swallows a coincident tick; only real increments can hit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            snapHi     <= '0;
            cmp        <= '0;
            ctrlEn     <= 1'b0;
            ctrlIrqEn  <= 1'b0;
            pend       <= 1'b0;
            wdogReload <= '0;
            timerIrq   <= 1'b0;
            heldData   <= '0;
        end else begin
            if (wrCntLo) begin
                cnt[31:0] <= mmio.mmioInData;
            end else if (wrCntHi) begin
                cnt[63:32] <= mmio.mmioInData;
            end else if (cntTick) begin
                cnt <= cntNext;
            end

            if (rdCntLo) begin
                snapHi <= cnt[63:32];
            end

            if (wrCmpLo) begin
                cmp[31:0] <= mmio.mmioInData;
            end
            if (wrCmpHi) begin
                cmp[63:32] <= mmio.mmioInData;
            end

            if (wrCtrl) begin
                ctrlEn    <= mmio.mmioInData[CTRL_EN_BIT];
                ctrlIrqEn <= mmio.mmioInData[CTRL_IRQEN_BIT];
            end

            if (cmpHit) begin
                pend <= 1'b1;
            end else if (wrStatus && mmio.mmioInData[STATUS_PEND_BIT]) begin
                pend <= 1'b0;
            end

            if (wrReload) begin
                wdogReload <= mmio.mmioInData;
            end

            timerIrq <= pend && ctrlIrqEn;

            if (accessFire) begin
                heldData <= isRead ? readData : '0;
            end
        end
    end

    mmi_tick_wdog wdog (
        .clock       (clock),
        .reset       (reset),
        .reloadValue (mmio.mmioInData),
        .load        (wrReload),
        .tick        (timer1kHz),
        .curValue    (wdogCur),
        .expire      (wdogExpire)
    );

endmodule

// File: doc/mmi_mod_tick_timer.md
MMI_MOD_TICK_TIMER -- requirements
Module: mmi_mod_tick_timer

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL provide ports as listed:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- timer1MHz  in  1  one-cycle microsecond tick pulse from the clock pulser
- timer1kHz  in  1  one-cycle millisecond tick pulse from the clock pulser
- mmioAddr  in  4  word register index
- mmioOpm  in  2  request: 00 idle, 01 read, 10 write, 11 reserved (treated as idle)
- mmioInData  in  32  write data
- mmioOutData  out  32  read data
- mmioOK  out  2  response: 00 idle, 01 done
- timerIrq  out  1  level interrupt, compare hit pending and enabled
- wdogExpire  out  1  one-cycle pulse on watchdog expiry

Function
REQ-003 SHALL keep a 64-bit microsecond counter CNT, incremented by 1 on each cycle with timer1MHz=1 while CTRL.EN=1, wrapping from all-ones to zero.
REQ-004 SHALL use this register map (word index): 0 CNT_LO, 1 CNT_HI, 2 CMP_LO, 3 CMP_HI, 4 CTRL (bit0 EN, bit1 IRQEN), 5 STATUS (bit0 PEND, write-1-to-clear), 6 WDOG_RELOAD, 7 WDOG_CUR (read-only); indices 8-15 read as zero and ignore writes.
REQ-005 Reading CNT_LO SHALL return the live low word and snapshot the live high word into SNAP_HI in the same cycle; reading CNT_HI SHALL return SNAP_HI.
REQ-006 Writing CNT_LO or CNT_HI SHALL replace that half of CNT; a tick coinciding with a CNT write SHALL be dropped.
REQ-007 PEND SHALL set when an increment makes CNT equal to {CMP_HI,CMP_LO}; CMP writes or CNT writes alone SHALL NOT set PEND.
REQ-008 If PEND set and a write-1-to-clear occur in the same cycle, PEND SHALL remain set.
REQ-009 timerIrq SHALL equal PEND AND CTRL.IRQEN, registered, asserting one cycle after PEND sets.
REQ-010 Writing WDOG_RELOAD SHALL load both WDOG_RELOAD and WDOG_CUR; WDOG_CUR SHALL decrement by 1 on each timer1kHz pulse while nonzero.
REQ-011 On the WDOG_CUR 1->0 transition, wdogExpire SHALL pulse high for exactly one cycle; WDOG_CUR SHALL stay 0 with no further pulses until reloaded; a reload coinciding with a tick SHALL win, with no pulse.
REQ-012 The MMIO state machine SHALL have two states:
- IDLE: on mmioOpm 01 or 10, perform the access once and go to DONE.
- DONE: drive mmioOK=01 and hold mmioOutData until mmioOpm returns to 00, then go to IDLE with mmioOK=00.
REQ-013 Access latency SHALL be exactly one cycle, request to mmioOK=01; a held request SHALL NOT repeat its side effects (write, snapshot, W1C).
REQ-014 mmioOutData SHALL be zero for writes and whenever the machine is in IDLE.

Reset
REQ-015 Reset SHALL clear the following to zero: CNT, SNAP_HI, CMP, CTRL, PEND, WDOG_RELOAD, WDOG_CUR, timerIrq, wdogExpire, mmioOutData and mmioOK; the state machine SHALL go to IDLE.
REQ-016 Reset asserted during DONE SHALL abort the access; after release, a still-held request SHALL be serviced as new.

Structure
REQ-017 Register indices, mmioOpm/mmioOK encodings and CTRL/STATUS bit positions SHALL live in shared package mmi_timer_pkg.
REQ-018 The watchdog (REQ-010/011) SHALL be a sub-module mmi_tick_wdog with 32-bit reload input, load strobe, tick input, current value and expire outputs.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- EN=1, 5 timer1MHz pulses -> CNT_LO reads 5; EN=0, 3 pulses -> CNT_LO still 5.
- CNT written to 0x00000000_FFFFFFFF, one tick -> CNT_LO read returns 0, CNT_HI read returns 1.
- CMP=10, IRQEN=1, EN=1, 10 ticks -> timerIrq high one cycle after the 10th tick; W1C STATUS coinciding with a new hit -> PEND stays 1.
- WDOG_RELOAD=3, 3 timer1kHz pulses -> wdogExpire single pulse after the 3rd; further pulses -> no pulse, WDOG_CUR=0.
- Write held 6 cycles -> mmioOK=01 from cycle 1, write applied once; reset mid-DONE -> mmioOK=00 at once.
- CNT_HI write coinciding with a tick -> tick dropped, CNT equals the written value.
